// File: rtl/fixed_point_divide_if.sv
// Request/result bundle for the sequential fixed-point divider.
// master issues operands and start; slave returns busy/done and the result.
interface fixed_point_divide_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic                  overflow;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, overflow, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_point_divide.sv
// Signed Q(INT).(FRACT) divider: radix-2 restoring division on magnitudes,
// one quotient bit per clock, sign and saturation applied on the last step.
module fixed_point_divide #(
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 8,
    parameter int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH
) (
    input logic clk,
    input logic rst_n,
    fixed_point_divide_if.slave bus
);
    localparam int N  = DATA_WIDTH + FRACT_WIDTH;
    localparam int CW = $clog2(N);
    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [N-1:0] LIM_POS = {{(N-DATA_WIDTH){1'b0}}, MAX_POS};
    localparam logic [N-1:0] LIM_NEG = {{(N-DATA_WIDTH){1'b0}}, MIN_NEG};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [N-1:0]          num;
    logic [N-1:0]          q;
    logic [DATA_WIDTH:0]   rem;
    logic [DATA_WIDTH-1:0] dmag;
    logic                  sign;
    logic [CW-1:0]         cnt;

    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   rem_nx;
    logic                  ge;
    logic [N-1:0]          q_nx;
    logic [DATA_WIDTH-1:0] q_lo;
    logic [DATA_WIDTH-1:0] res;
    logic                  ovf;

    // 0x8000-style operands negate to 2^(DATA_WIDTH-1) as unsigned
    assign a_mag = bus.dividend[MSB] ? -bus.dividend : bus.dividend;
    assign b_mag = bus.divisor[MSB]  ? -bus.divisor  : bus.divisor;

    always_comb begin
        rem_sh = {rem[DATA_WIDTH-1:0], num[N-1]};
        ge     = rem_sh >= {1'b0, dmag};
        rem_nx = ge ? rem_sh - {1'b0, dmag} : rem_sh;
        q_nx   = {q[N-2:0], ge};
        q_lo   = q_nx[DATA_WIDTH-1:0];
        res    = sign ? -q_lo : q_lo;
        ovf    = 1'b0;
        if (!sign && q_nx > LIM_POS) begin
            res = MAX_POS;
            ovf = 1'b1;
        end else if (sign && q_nx > LIM_NEG) begin
            res = MIN_NEG;
            ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            num             <= '0;
            q               <= '0;
            rem             <= '0;
            dmag            <= '0;
            sign            <= 1'b0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign     <= bus.dividend[MSB] ^ bus.divisor[MSB];
                        dmag     <= b_mag;
                        bus.busy <= 1'b1;
                        if (bus.divisor == '0) begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.quotient    <= bus.dividend[MSB] ? MIN_NEG : MAX_POS;
                            bus.overflow    <= 1'b0;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            num   <= {a_mag, {FRACT_WIDTH{1'b0}}};
                            rem   <= '0;
                            q     <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    num <= {num[N-2:0], 1'b0};
                    q   <= q_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N-1)) begin
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.quotient    <= res;
                        bus.overflow    <= ovf;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_divide.sv
// Directed bench for fixed_point_divide with a queue of expected results.
// Expectations come from an integer reference model of the Q8.8 division.
module tb_fixed_point_divide;
    typedef struct {
        logic [15:0] q;
        logic        ov;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    fixed_point_divide_if #(.DATA_WIDTH(16)) bus ();

    fixed_point_divide dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint sa, sb_, ma, mb, qm;
        bit     neg;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb_ < 0) ? -sb_ : sb_;
        e.ov = 1'b0;
        e.dz = 1'b0;
        if (sb_ == 0) begin
            e.q = (sa < 0) ? 16'h8000 : 16'h7FFF;
            e.dz = 1'b1;
            e.lat = 0;
        end else begin
            qm = (ma * 256) / mb;
            neg = (sa < 0) != (sb_ < 0);
            e.lat = 24;
            if (!neg && qm > 32767) begin
                e.q = 16'h7FFF;
                e.ov = 1'b1;
            end else if (neg && qm > 32768) begin
                e.q = 16'h8000;
                e.ov = 1'b1;
            end else begin
                e.q = neg ? 16'(-qm) : 16'(qm);
            end
        end
        return e;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic compare(input string tag, input int lat, input int busy_n);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_q"}, 32'(bus.quotient), 32'(e.q));
        check({tag, "_ov"}, 32'(bus.overflow), 32'(e.ov));
        check({tag, "_dz"}, 32'(bus.div_by_zero), 32'(e.dz));
        if (lat >= 0) begin
            check({tag, "_lat"}, 32'(lat), 32'(e.lat));
            check({tag, "_busy"}, 32'(busy_n), 32'(e.lat + 1));
        end
    endtask

    task automatic run_div(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input bit disturb);
        int n = 0;
        int busy_n = 0;
        wait_idle();
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.dividend = a;
        bus.divisor = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor = 16'($urandom);
        while (!bus.done && n < 60) begin
            busy_n += int'(bus.busy);
            @(posedge clk);
            #1;
            n++;
            bus.start = disturb && (n == 5 || n == 24);
            if (bus.start) begin
                bus.dividend = 16'h0100;
                bus.divisor = 16'h0400;
            end
        end
        busy_n += int'(bus.busy);
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        compare(tag, n, busy_n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int edge_n;
        int first;
        int seen;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_flags", {30'd0, bus.overflow, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("d3_2", 16'h0300, 16'h0200, 1'b0);
        run_div("dm1_3", 16'hFF00, 16'h0300, 1'b0);
        run_div("d1_m3", 16'h0100, 16'hFD00, 1'b0);
        run_div("sat_pos", 16'h7F00, 16'h0080, 1'b0);
        run_div("min_neg", 16'h8000, 16'h0100, 1'b0);
        run_div("m128_m1", 16'h8000, 16'hFF00, 1'b0);
        run_div("zero_num", 16'h0000, 16'hFD00, 1'b0);
        run_div("dz_neg", 16'hFE00, 16'h0000, 1'b0);
        run_div("dz_pos", 16'h0100, 16'h0000, 1'b0);
        run_div("ignore", 16'h0300, 16'h0200, 1'b1);

        // start held high: two back-to-back divisions
        wait_idle();
        sb.push_back(model(16'h0300, 16'h0200));
        sb.push_back(model(16'h0300, 16'h0200));
        @(negedge clk);
        bus.dividend = 16'h0300;
        bus.divisor = 16'h0200;
        bus.start = 1'b1;
        edge_n = 0;
        first = 0;
        seen = 0;
        while (seen < 2 && edge_n < 120) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (bus.done) begin
                seen++;
                if (seen == 1) first = edge_n;
                else check("held_period", 32'(edge_n - first), 32'd26);
                compare("held", -1, 0);
            end
        end
        bus.start = 1'b0;
        check("held_two_dones", 32'(seen), 32'd2);

        // reset in the middle of CALC
        wait_idle();
        @(negedge clk);
        bus.dividend = 16'h0700;
        bus.divisor = 16'h0300;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_q", 32'(bus.quotient), 32'd0);
        check("arst_flags", {30'd0, bus.overflow, bus.div_by_zero}, 32'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen += int'(bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen += int'(bus.done);
        end
        check("arst_no_done", 32'(seen), 32'd0);
        run_div("post_rst", 16'h0300, 16'h0200, 1'b0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
